// File: rtl/display_arb_pkg.sv
// Shared types and helpers for the display arbiter.
//   arb_state_t : arbiter FSM states
//   digits_t    : four packed BCD/hex digits {d3,d2,d1,d0}
//   rr_pick     : round-robin one-hot pick, scanning upward from ptr modulo n
package display_arb_pkg;

    typedef enum logic {IDLE, HOLD} arb_state_t;

    typedef logic [15:0] digits_t;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned MAX_REQ = 8;

    // First set bit of req at or after ptr, wrapping at n. Bits at or above n are ignored.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [2:0]         ptr,
                                                   input int unsigned        n);
        logic [MAX_REQ-1:0] pick;
        logic               found;
        int unsigned        j;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            j = (32'(ptr) + k) % n;
            if (k < n && !found && req[j[2:0]]) begin
                pick[j[2:0]] = 1'b1;
                found        = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index with highest priority this round
//   win     : one-hot winner (zero if no request)
//   win_idx : binary index of the winner
//   valid   : at least one request present
module rr_picker
    import display_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [PTR_W-1:0]   win_idx,
    output logic               valid
);

    logic [MAX_REQ-1:0] pick_full;

    always_comb begin
        pick_full = rr_pick(MAX_REQ'(req), 3'(ptr), NUM_REQ);
        win       = pick_full[NUM_REQ-1:0];
        valid     = |pick_full;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win[i]) win_idx = PTR_W'(i);
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Shares a 4-digit 7-segment display between NUM_REQ requesters.
// Round-robin grant with a minimum dwell of DWELL_CYCLES per holder; the holder's
// req_data slice is registered onto in3..in0 every cycle while granted.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : level request per requester
//   req_data  : {d3,d2,d1,d0} per requester, requester i at [16i+15:16i]
//   grant     : registered one-hot grant
//   in0..in3  : registered digits to the display driver (in0 rightmost)
//   switched  : one-cycle pulse on every grant change, including to/from none
// Optional build macro DISPLAY_ARB_PREEMPT_EN: req[0] is urgent and interrupts
// any other holder's dwell.
module display_arbiter
    import display_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter digits_t     IDLE_DIGITS  = 16'h0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*16-1:0]   req_data,
    output logic [NUM_REQ-1:0]      grant,
    output logic [DIGIT_W-1:0]      in0,
    output logic [DIGIT_W-1:0]      in1,
    output logic [DIGIT_W-1:0]      in2,
    output logic [DIGIT_W-1:0]      in3,
    output logic                    switched
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

`ifdef DISPLAY_ARB_PREEMPT_EN
    localparam bit PREEMPT_EN = 1'b1;
`else
    localparam bit PREEMPT_EN = 1'b0;
`endif

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    digits_t            digits_q, digits_d;
    logic               switched_q, switched_d;

    logic [NUM_REQ-1:0] win;
    logic [PTR_W-1:0]   win_idx;
    logic               win_valid;

    logic holder_req, dwell_done, urgent, keep_urgent;
    logic take_win, go_idle;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req     (req),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx),
        .valid   (win_valid)
    );

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
        return (idx == PTR_LAST) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        switched_d = 1'b0;
        take_win   = 1'b0;
        go_idle    = 1'b0;

        holder_req  = |(req & grant_q);
        dwell_done  = (cnt_q == CNT_LAST);
        // Urgent requester 0 steals the display from anyone else immediately.
        urgent      = PREEMPT_EN && req[0] && !grant_q[0];
        keep_urgent = PREEMPT_EN && req[0] && grant_q[0];

        case (state_q)
            IDLE: begin
                if (win_valid) take_win = 1'b1;
            end
            HOLD: begin
                if (urgent) begin
                    grant_d    = NUM_REQ'(1);
                    ptr_d      = PTR_W'(1);
                    cnt_d      = '0;
                    switched_d = 1'b1;
                end else if (!holder_req) begin
                    if (win_valid) take_win = 1'b1;
                    else           go_idle  = 1'b1;
                end else if (dwell_done) begin
                    cnt_d = '0;
                    // ptr already points past the holder, so win == grant_q means
                    // nobody else is waiting.
                    if (!keep_urgent && win != grant_q) take_win = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (take_win) begin
            state_d    = HOLD;
            grant_d    = win;
            ptr_d      = ptr_after(win_idx);
            cnt_d      = '0;
            switched_d = 1'b1;
        end
        if (go_idle) begin
            state_d    = IDLE;
            grant_d    = '0;
            cnt_d      = '0;
            switched_d = (grant_q != '0);
        end

        // Digits follow the next holder so they change on the same edge as grant.
        digits_d = IDLE_DIGITS;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_d[i]) digits_d = req_data[16*i +: 16];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            digits_q   <= IDLE_DIGITS;
            switched_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            digits_q   <= digits_d;
            switched_q <= switched_d;
        end
    end

    assign grant    = grant_q;
    assign in0      = digits_q[3:0];
    assign in1      = digits_q[7:4];
    assign in2      = digits_q[11:8];
    assign in3      = digits_q[15:12];
    assign switched = switched_q;

endmodule
